stopwatch_display: RTL and testbench

- Consumer side of the stopwatch time bus: takes the binary minutes/seconds values produced by the select/adjust stage and drives the 4-digit multiplexed seven-segment display.
- Converts each 0..59 field to two BCD digits and time-multiplexes the anodes.
- In adjust mode, blinks the field currently being adjusted; digit 2's decimal point serves as the MM.SS separator.
- Sits between the time counters/adjust logic and the board display pins.

---
 rtl/stopwatch_display.sv | 91 +++++++++
 tb/tb_stopwatch_display.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/stopwatch_display.sv
// stopwatch_display: mm:ss to 4-digit muxed 7-seg with adjust-field blink; clk/rst, minutes/seconds[5:0], adj, sel(1=sec), blink_clk (async) in; an[3:0], seg[7:0]={dp,g..a} active-low out
module stopwatch_display #(
  parameter int SCAN_DIV = 100000,
  parameter int CNT_W    = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       adj,
  input  logic       sel,
  input  logic       blink_clk,
  output logic [3:0] an,
  output logic [7:0] seg
);
  logic [CNT_W-1:0] div_q, div_d;
  logic [1:0] idx_q, idx_d;
  logic [5:0] min_q, min_d, sec_q, sec_d;
  logic s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic phase_q, phase_d;
  logic [3:0] an_q, an_d;
  logic [7:0] seg_q, seg_d;
  logic wrap, blank;
  logic [5:0] field, digit;
  logic [6:0] code;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0: seg_code = 7'b1000000;
      4'd1: seg_code = 7'b1111001;
      4'd2: seg_code = 7'b0100100;
      4'd3: seg_code = 7'b0110000;
      4'd4: seg_code = 7'b0011001;
      4'd5: seg_code = 7'b0010010;
      4'd6: seg_code = 7'b0000010;
      4'd7: seg_code = 7'b1111000;
      4'd8: seg_code = 7'b0000000;
      4'd9: seg_code = 7'b0010000;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    wrap = div_q == CNT_W'(SCAN_DIV - 1);
    div_d = wrap ? '0 : div_q + 1'b1;
    idx_d = wrap ? idx_q + 2'd1 : idx_q;
    min_d = minutes;
    sec_d = seconds;
    s1_d = blink_clk;
    s2_d = s1_q;
    s3_d = s2_q;
    // leaving adjust mode clears the phase so re-entry starts visible
    phase_d = adj & (phase_q ^ (s2_q & ~s3_q));
    field = idx_q[1] ? min_q : sec_q;
    digit = idx_q[0] ? field / 6'd10 : field % 6'd10;
    code = (field > 6'd59) ? 7'b0111111 : seg_code(digit[3:0]);
    // sel=1 blanks the seconds digits (idx 0,1), sel=0 the minutes digits (idx 2,3)
    blank = adj & phase_q & (sel ^ idx_q[1]);
    an_d = blank ? 4'hF : ~(4'b0001 << idx_q);
    seg_d = blank ? 8'hFF : {idx_q != 2'd2, code};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
      min_q <= '0;
      sec_q <= '0;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
      phase_q <= 1'b0;
      an_q <= 4'hF;
      seg_q <= 8'hFF;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      min_q <= min_d;
      sec_q <= sec_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      phase_q <= phase_d;
      an_q <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an = an_q;
  assign seg = seg_q;
endmodule

// File: tb/tb_stopwatch_display.sv
// tb_stopwatch_display: random + directed check of stopwatch_display against a cycle-count based model
module tb_stopwatch_display;
  localparam int SCAN = 4;
  logic clk = 0, rst = 1, adj = 0, sel = 0, blink_clk = 0;
  logic [5:0] minutes = 6'd12, seconds = 6'd34;
  logic [3:0] an;
  logic [7:0] seg;
  int total = 0, bad = 0;

  stopwatch_display #(.SCAN_DIV(SCAN), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .minutes(minutes), .seconds(seconds),
    .adj(adj), .sel(sel), .blink_clk(blink_clk), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  logic [6:0] lut [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic [3:0] exp_an;
  logic [7:0] exp_seg;
  bit mvalid = 0;
  int t = 0, cm = 0, cs = 0, idx, fld, dg;
  bit h0, h1, h2, ph, blank;

  // model: digit index follows from cycles since reset; captured fields are last cycle's inputs;
  // a synchronized rising edge is the blink input seen high two samples ago and low three ago
  always @(posedge clk) begin
    if (rst) begin
      exp_an = 4'hF; exp_seg = 8'hFF;
      t = 0; cm = 0; cs = 0; h0 = 0; h1 = 0; h2 = 0; ph = 0;
    end else begin
      idx = (t / SCAN) % 4;
      fld = idx >= 2 ? cm : cs;
      dg = (idx % 2 == 1) ? fld / 10 : fld % 10;
      blank = adj && ph && (sel ? idx < 2 : idx >= 2);
      exp_an = blank ? 4'hF : 4'hF ^ 4'(1 << idx);
      exp_seg = blank ? 8'hFF : {(idx != 2), (fld > 59 ? 7'b0111111 : lut[dg])};
      ph = adj && (ph ^ (h1 && !h2));
      h2 = h1; h1 = h0; h0 = blink_clk;
      cm = minutes; cs = seconds;
      t++;
    end
    mvalid = 1;
  end

  bit lit_en = 0;
  logic [3:0] lit_an;
  logic [7:0] lit_seg;
  string lit_name = "";

  always @(negedge clk) if (mvalid) begin
    total++;
    if (an !== exp_an || seg !== exp_seg) begin
      bad++;
      $display("FAIL model @%0t: an=%b seg=%b, expected an=%b seg=%b", $time, an, seg, exp_an, exp_seg);
    end
    if (lit_en) begin
      total++;
      if (an !== lit_an || seg !== lit_seg) begin
        bad++;
        $display("FAIL %s @%0t: an=%b seg=%b, expected an=%b seg=%b", lit_name, $time, an, seg, lit_an, lit_seg);
      end
    end
  end

  int e = 0;

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic go(input int k);
    while (e < k) begin step(1); e++; end
  endtask

  task automatic lit(input string nm, input logic [3:0] a, input logic [7:0] s);
    lit_name = nm; lit_an = a; lit_seg = s; lit_en = 1;
    @(negedge clk); #1;
    lit_en = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    step(2);
    rst = 0;
    e = 0;
  endtask

  initial begin
    // reset hold and first scan pass with 12:34
    rst = 1;
    repeat (3) begin step(1); lit("reset_hold", 4'hF, 8'hFF); end
    rst = 0; e = 0;
    go(1);  lit("first_after_reset", 4'b1110, 8'b11000000);
    go(2);  lit("scan_d0", 4'b1110, 8'b10011001);
    go(5);  lit("scan_d1", 4'b1101, 8'b10110000);
    go(9);  lit("scan_d2", 4'b1011, 8'b00100100);
    go(13); lit("scan_d3", 4'b0111, 8'b11111001);
    go(17); lit("scan_wrap", 4'b1110, 8'b10011001);
    // 59:00
    minutes = 6'd59; seconds = 6'd0; do_reset();
    go(2);  lit("b59_d0", 4'b1110, 8'b11000000);
    go(5);  lit("b59_d1", 4'b1101, 8'b11000000);
    go(9);  lit("b59_d2", 4'b1011, 8'b00010000);
    go(13); lit("b59_d3", 4'b0111, 8'b10010010);
    // illegal seconds
    minutes = 6'd12; seconds = 6'd63; do_reset();
    go(2);  lit("ill_d0", 4'b1110, 8'b10111111);
    go(5);  lit("ill_d1", 4'b1101, 8'b10111111);
    go(9);  lit("ill_d2", 4'b1011, 8'b00100100);
    go(13); lit("ill_d3", 4'b0111, 8'b11111001);
    // minutes change mid-scan: two-cycle latency onto idx2
    seconds = 6'd34; do_reset();
    go(9);  minutes = 6'd17;
    lit("chg_old", 4'b1011, 8'b00100100);
    go(10); lit("chg_still_old", 4'b1011, 8'b00100100);
    go(11); lit("chg_new", 4'b1011, 8'b01111000);
    // blink seconds field
    minutes = 6'd12; adj = 1; sel = 1; blink_clk = 1; do_reset();
    go(4);  lit("blk_s_d0", 4'hF, 8'hFF);
    go(8);  lit("blk_s_d1", 4'hF, 8'hFF);
    go(9);  lit("blk_s_d2", 4'b1011, 8'b00100100);
    blink_clk = 0;
    go(12); blink_clk = 1;
    go(17); lit("blk_s_2nd_edge", 4'b1110, 8'b10011001);
    // blink minutes then drop adj
    sel = 0; blink_clk = 1; do_reset();
    go(9);  lit("blk_m_d2", 4'hF, 8'hFF);
    adj = 0;
    go(10); lit("adj_off", 4'b1011, 8'b00100100);
    // reset in blank phase while idx2 is selected
    adj = 1; do_reset();
    go(10);
    rst = 1; step(1);
    lit("mid_reset", 4'hF, 8'hFF);
    rst = 0; e = 0;
    go(1);  lit("mid_reset_release", 4'b1110, 8'b11000000);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      step(1);
      if ($urandom_range(0, 3) == 0) minutes = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) seconds = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 5) == 0) blink_clk = ~blink_clk;
      if ($urandom_range(0, 39) == 0) adj = ~adj;
      if ($urandom_range(0, 19) == 0) sel = ~sel;
      rst = ($urandom_range(0, 299) == 0);
    end
    rst = 0;
    step(2);
    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
